race_sequencer: RTL and testbench

Top-level game sequencer for epic_racer, clocked on the 65 MHz pixel clock. Steps the race through title, countdown, racing and finish phases. Drives the layer-visibility flags of the draw_img chain (background/track/car) and the car_ctl enable. Counts frames from the VGA vsync, laps from the finish-line detector, and elapsed race seconds.

---
 rtl/race_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_race_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/race_sequencer.sv
// Game-phase sequencer for epic_racer: title, countdown, race and finish, with
// frame/lap/second counters. Define PAUSE_EN to add the in-race pause input.
module race_sequencer #(
  parameter int unsigned FRAMES_PER_SEC = 60,
  parameter int unsigned COUNTDOWN_SECS = 3,
  parameter int unsigned LAPS           = 3,
  parameter int unsigned LAP_W          = 3,
  parameter int unsigned MIN_LAP_FRAMES = 120
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic             vsync_in,
  input  logic             start,
  input  logic             lap_cross,
`ifdef PAUSE_EN
  input  logic             pause,
`endif
  output logic             bg_visible,
  output logic             track_visible,
  output logic             player_visible,
  output logic             car_en,
  output logic [1:0]       countdown,
  output logic [LAP_W-1:0] lap_count,
  output logic [9:0]       race_time_s,
  output logic             race_done
);

  localparam int unsigned FC_W    = $clog2(FRAMES_PER_SEC);
  localparam int unsigned GUARD_W = (MIN_LAP_FRAMES < 1) ? 1 : $clog2(MIN_LAP_FRAMES + 1);
  localparam int unsigned TIME_W  = 10;

  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(FRAMES_PER_SEC - 1);
  localparam logic [LAP_W-1:0]   LAP_LAST   = LAP_W'(LAPS - 1);
  localparam logic [GUARD_W-1:0] GUARD_INIT = GUARD_W'(MIN_LAP_FRAMES);
  localparam logic [1:0]         CD_INIT    = 2'(COUNTDOWN_SECS);
  localparam logic [TIME_W-1:0]  TIME_MAX   = 10'd999;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_RACE      = 2'd2,
    ST_FINISH    = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic               vsync_prev_q, vsync_prev_d;
  logic               start_prev_q, start_prev_d;
  logic               lap_prev_q,   lap_prev_d;
  logic [FC_W-1:0]    frame_cnt_q,  frame_cnt_d;
  logic [GUARD_W-1:0] guard_q,      guard_d;

  logic               bg_visible_q,     bg_visible_d;
  logic               track_visible_q,  track_visible_d;
  logic               player_visible_q, player_visible_d;
  logic               car_en_q,         car_en_d;
  logic [1:0]         countdown_q,      countdown_d;
  logic [LAP_W-1:0]   lap_count_q,      lap_count_d;
  logic [TIME_W-1:0]  race_time_q,      race_time_d;
  logic               race_done_q,      race_done_d;

  logic tick;
  logic start_e;
  logic cross_e;
  logic sec_wrap;
  logic run;
  logic lap_ok;
  logic lap_final;

  assign tick     = vsync_in  & ~vsync_prev_q;
  assign start_e  = start     & ~start_prev_q;
  assign cross_e  = lap_cross & ~lap_prev_q;
  assign sec_wrap = tick & (frame_cnt_q == FC_LAST);

`ifdef PAUSE_EN
  logic pause_prev_q, pause_prev_d;
  logic paused_q,     paused_d;
  logic pause_e;

  assign pause_e = pause & ~pause_prev_q;
  assign run     = ~paused_q;
`else
  assign run     = 1'b1;
`endif

  // A crossing counts only while racing, unpaused, and outside the guard window.
  assign lap_ok    = (state_q == ST_RACE) & run & cross_e & (guard_q == '0);
  assign lap_final = lap_ok & (lap_count_q == LAP_LAST);

  // State and datapath registers
  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      vsync_prev_q     <= 1'b0;
      start_prev_q     <= 1'b1;
      lap_prev_q       <= 1'b1;
      frame_cnt_q      <= '0;
      guard_q          <= '0;
      bg_visible_q     <= 1'b1;
      track_visible_q  <= 1'b0;
      player_visible_q <= 1'b0;
      car_en_q         <= 1'b0;
      countdown_q      <= '0;
      lap_count_q      <= '0;
      race_time_q      <= '0;
      race_done_q      <= 1'b0;
`ifdef PAUSE_EN
      pause_prev_q     <= 1'b1;
      paused_q         <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      vsync_prev_q     <= vsync_prev_d;
      start_prev_q     <= start_prev_d;
      lap_prev_q       <= lap_prev_d;
      frame_cnt_q      <= frame_cnt_d;
      guard_q          <= guard_d;
      bg_visible_q     <= bg_visible_d;
      track_visible_q  <= track_visible_d;
      player_visible_q <= player_visible_d;
      car_en_q         <= car_en_d;
      countdown_q      <= countdown_d;
      lap_count_q      <= lap_count_d;
      race_time_q      <= race_time_d;
      race_done_q      <= race_done_d;
`ifdef PAUSE_EN
      pause_prev_q     <= pause_prev_d;
      paused_q         <= paused_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start_e)                          state_d = ST_COUNTDOWN;
      ST_COUNTDOWN: if (sec_wrap && countdown_q == 2'd1)  state_d = ST_RACE;
      ST_RACE:      if (lap_final)                        state_d = ST_FINISH;
      ST_FINISH:    if (start_e)                          state_d = ST_IDLE;
      default:                                            state_d = ST_IDLE;
    endcase
  end

  // Output and counter next values
  always_comb begin
    vsync_prev_d     = vsync_in;
    start_prev_d     = start;
    lap_prev_d       = lap_cross;
    frame_cnt_d      = frame_cnt_q;
    guard_d          = guard_q;
    bg_visible_d     = bg_visible_q;
    track_visible_d  = track_visible_q;
    player_visible_d = player_visible_q;
    car_en_d         = car_en_q;
    countdown_d      = countdown_q;
    lap_count_d      = lap_count_q;
    race_time_d      = race_time_q;
    race_done_d      = race_done_q;
`ifdef PAUSE_EN
    pause_prev_d     = pause;
    paused_d         = paused_q;
`endif

    case (state_q)
      ST_IDLE: begin
        bg_visible_d = 1'b1;
        if (start_e) begin
          countdown_d      = CD_INIT;
          frame_cnt_d      = '0;
          lap_count_d      = '0;
          race_time_d      = '0;
          guard_d          = '0;
          track_visible_d  = 1'b1;
          player_visible_d = 1'b1;
        end
      end

      ST_COUNTDOWN: begin
        if (sec_wrap) begin
          frame_cnt_d = '0;
          countdown_d = 2'(countdown_q - 2'd1);
          if (countdown_q == 2'd1) car_en_d = 1'b1;
        end else if (tick) begin
          frame_cnt_d = FC_W'(frame_cnt_q + 1'b1);
        end
      end

      ST_RACE: begin
        if (run && tick) begin
          if (sec_wrap) begin
            frame_cnt_d = '0;
            if (race_time_q != TIME_MAX) race_time_d = TIME_W'(race_time_q + 1'b1);
          end else begin
            frame_cnt_d = FC_W'(frame_cnt_q + 1'b1);
          end
          if (guard_q != '0) guard_d = GUARD_W'(guard_q - 1'b1);
        end
`ifdef PAUSE_EN
        if (pause_e) begin
          paused_d = ~paused_q;
          car_en_d = paused_q;
        end
`endif
        // A fresh crossing reloads the guard, overriding this cycle's decrement.
        if (lap_ok) begin
          lap_count_d = LAP_W'(lap_count_q + 1'b1);
          guard_d     = GUARD_INIT;
        end
        if (lap_final) begin
          car_en_d    = 1'b0;
          race_done_d = 1'b1;
`ifdef PAUSE_EN
          paused_d    = 1'b0;
`endif
        end
      end

      ST_FINISH: begin
        if (start_e) begin
          race_done_d      = 1'b0;
          track_visible_d  = 1'b0;
          player_visible_d = 1'b0;
        end
      end

      default: ;
    endcase
  end

  assign bg_visible     = bg_visible_q;
  assign track_visible  = track_visible_q;
  assign player_visible = player_visible_q;
  assign car_en         = car_en_q;
  assign countdown      = countdown_q;
  assign lap_count      = lap_count_q;
  assign race_time_s    = race_time_q;
  assign race_done      = race_done_q;

endmodule

// File: tb/tb_race_sequencer.sv
// Directed bench for race_sequencer with short frame/lap parameters.
// Exercises the PAUSE_EN feature when that macro is defined.
module tb_race_sequencer;

  localparam int unsigned LAP_W = 3;

  logic             pclk = 1'b0;
  logic             rst;
  logic             vsync_in;
  logic             start;
  logic             lap_cross;
`ifdef PAUSE_EN
  logic             pause;
`endif
  logic             bg_visible;
  logic             track_visible;
  logic             player_visible;
  logic             car_en;
  logic [1:0]       countdown;
  logic [LAP_W-1:0] lap_count;
  logic [9:0]       race_time_s;
  logic             race_done;

  int n_cmp = 0;
  int n_err = 0;

  race_sequencer #(
    .FRAMES_PER_SEC(4),
    .COUNTDOWN_SECS(3),
    .LAPS(2),
    .LAP_W(LAP_W),
    .MIN_LAP_FRAMES(5)
  ) dut (
    .pclk(pclk),
    .rst(rst),
    .vsync_in(vsync_in),
    .start(start),
    .lap_cross(lap_cross),
`ifdef PAUSE_EN
    .pause(pause),
`endif
    .bg_visible(bg_visible),
    .track_visible(track_visible),
    .player_visible(player_visible),
    .car_en(car_en),
    .countdown(countdown),
    .lap_count(lap_count),
    .race_time_s(race_time_s),
    .race_done(race_done)
  );

  always #5 pclk = ~pclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int bg, input int trk, input int ply,
                            input int car, input int cd, input int lap, input int tm,
                            input int done);
    check_eq({tag, ".bg"},     32'(bg_visible),     32'(bg));
    check_eq({tag, ".track"},  32'(track_visible),  32'(trk));
    check_eq({tag, ".player"}, 32'(player_visible), 32'(ply));
    check_eq({tag, ".car_en"}, 32'(car_en),         32'(car));
    check_eq({tag, ".cd"},     32'(countdown),      32'(cd));
    check_eq({tag, ".lap"},    32'(lap_count),      32'(lap));
    check_eq({tag, ".time"},   32'(race_time_s),    32'(tm));
    check_eq({tag, ".done"},   32'(race_done),      32'(done));
  endtask

  // One vsync rising edge; all drives and samples happen on negedges.
  task automatic frame_tick();
    vsync_in = 1'b1;
    repeat (2) @(negedge pclk);
    vsync_in = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic tick_with_cross();
    vsync_in  = 1'b1;
    lap_cross = 1'b1;
    @(negedge pclk);
    lap_cross = 1'b0;
    @(negedge pclk);
    vsync_in  = 1'b0;
    repeat (2) @(negedge pclk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    @(negedge pclk);
  endtask

  task automatic pulse_cross();
    lap_cross = 1'b1;
    @(negedge pclk);
    lap_cross = 1'b0;
    @(negedge pclk);
  endtask

`ifdef PAUSE_EN
  task automatic pulse_pause();
    pause = 1'b1;
    @(negedge pclk);
    pause = 1'b0;
    @(negedge pclk);
  endtask
`endif

  initial begin
    rst       = 1'b1;
    start     = 1'b1;
    vsync_in  = 1'b0;
    lap_cross = 1'b0;
`ifdef PAUSE_EN
    pause     = 1'b1;
`endif
    repeat (3) @(negedge pclk);
    rst = 1'b0;
    @(negedge pclk);
    check_outs("reset", 1, 0, 0, 0, 0, 0, 0, 0);

    // Start held through reset release is not an edge.
    repeat (10) frame_tick();
    check_outs("idle_hold", 1, 0, 0, 0, 0, 0, 0, 0);
    start = 1'b0;
`ifdef PAUSE_EN
    pause = 1'b0;
`endif
    @(negedge pclk);

    pulse_start();
    check_outs("cd_load", 1, 1, 1, 0, 3, 0, 0, 0);
    repeat (4) frame_tick();
    check_eq("cd_after4", 32'(countdown), 32'd2);
    repeat (4) frame_tick();
    check_eq("cd_after8", 32'(countdown), 32'd1);
    repeat (3) frame_tick();
    check_eq("cd_after11", 32'(countdown), 32'd1);
    check_eq("car_after11", 32'(car_en), 32'd0);
    frame_tick();
    check_outs("race_entry", 1, 1, 1, 1, 0, 0, 0, 0);

    repeat (8) frame_tick();
    check_eq("time_8ticks", 32'(race_time_s), 32'd2);

    // Lap guard: 5-frame window after a counted crossing.
    pulse_cross();
    check_eq("lap_first", 32'(lap_count), 32'd1);
    check_eq("done_first", 32'(race_done), 32'd0);
    repeat (3) frame_tick();
    pulse_cross();
    check_eq("lap_guarded", 32'(lap_count), 32'd1);
    repeat (3) frame_tick();
    pulse_cross();
    check_outs("finish", 1, 1, 1, 0, 0, 2, 3, 1);

    repeat (5) frame_tick();
    check_eq("finish_time_frozen", 32'(race_time_s), 32'd3);
    check_eq("finish_lap_frozen", 32'(lap_count), 32'd2);

    pulse_start();
    check_outs("to_idle", 1, 0, 0, 0, 0, 2, 3, 0);
    pulse_start();
    check_outs("cd_reload", 1, 1, 1, 0, 3, 0, 0, 0);
    repeat (12) frame_tick();
    check_eq("race2_car", 32'(car_en), 32'd1);

    // Long run to the 999 s ceiling.
    repeat (3995) frame_tick();
    check_eq("time_998", 32'(race_time_s), 32'd998);
    frame_tick();
    check_eq("time_999", 32'(race_time_s), 32'd999);
    repeat (8) frame_tick();
    check_eq("time_sat", 32'(race_time_s), 32'd999);

    // Crossing in the cycle the guard reaches zero is still ignored.
    pulse_cross();
    check_eq("lap2_first", 32'(lap_count), 32'd1);
    repeat (4) frame_tick();
    tick_with_cross();
    check_eq("lap2_guard_edge", 32'(lap_count), 32'd1);
    pulse_cross();
    check_outs("finish2", 1, 1, 1, 0, 0, 2, 999, 1);

    pulse_start();
    pulse_start();
    repeat (12) frame_tick();
    check_eq("race3_car", 32'(car_en), 32'd1);
    repeat (6) frame_tick();
    check_eq("race3_time", 32'(race_time_s), 32'd1);

`ifdef PAUSE_EN
    pulse_pause();
    check_eq("pause_car", 32'(car_en), 32'd0);
    repeat (8) frame_tick();
    check_eq("pause_time", 32'(race_time_s), 32'd1);
    check_eq("pause_car_hold", 32'(car_en), 32'd0);
    pulse_cross();
    check_eq("pause_cross_ignored", 32'(lap_count), 32'd0);
    pulse_pause();
    check_eq("unpause_car", 32'(car_en), 32'd1);
`endif

    pulse_cross();
    check_eq("race3_lap", 32'(lap_count), 32'd1);

    rst = 1'b1;
    @(negedge pclk);
    rst = 1'b0;
    check_outs("mid_reset", 1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge pclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
